cim_tile_model: RTL

Behavioural model of one compute-in-memory crossbar tile: the far end of the CIM interface that `conv_layer` and `fc_layer` drive. It latches the input vector written by a layer, performs an unsigned matrix-vector multiply against its stored weights, and returns per-column results through a registered read port. It is used for FPGA emulation and for closed-loop layer simulation in the perf-sim flow.

---
 rtl/cim_tile_model.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cim_tile_model.sv
// One compute-in-memory crossbar tile: latches an input vector, runs an unsigned
// matrix-vector multiply against stored weights, and serves saturated results.
module cim_tile_model #(
  parameter int unsigned xbar_size     = 256,
  parameter int unsigned datatype_size = 8,
  parameter int unsigned out_shift     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_we,
  input  logic [$clog2(xbar_size)-1:0]     i_wr_addr,
  input  logic [datatype_size-1:0]         i_wr_data,
  input  logic                             i_w_we,
  input  logic [$clog2(xbar_size)-1:0]     i_w_row,
  input  logic [$clog2(xbar_size)-1:0]     i_w_col,
  input  logic [datatype_size-1:0]         i_w_data,
  input  logic [$clog2(xbar_size):0]       i_rows,
  input  logic                             i_start,
  output logic                             o_busy,
  output logic                             o_done,
  input  logic [$clog2(xbar_size)-1:0]     i_rd_addr,
  output logic [datatype_size-1:0]         o_data
);

  localparam int unsigned addr_w = $clog2(xbar_size);
  localparam int unsigned rows_w = addr_w + 1;
  localparam int unsigned dw     = datatype_size;
  localparam int unsigned ACC_W  = 2 * datatype_size + $clog2(xbar_size);
  localparam int unsigned word_w = xbar_size * datatype_size;
  localparam logic [ACC_W-1:0] sat_max = {{(ACC_W - dw){1'b0}}, {dw{1'b1}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, FINISH} state_t;

  state_t                state_q, state_d;
  logic [word_w-1:0]     w_mem [xbar_size];
  logic [word_w-1:0]     w_rd_q;
  logic [dw-1:0]         in_q  [xbar_size];
  logic [dw-1:0]         out_q [xbar_size];
  logic [ACC_W-1:0]      acc_q [xbar_size];
  logic [dw-1:0]         in_fetch_q;
  logic [addr_w-1:0]     row_cnt_q;
  logic [rows_w-1:0]     n_rows_q;
  logic                  mac_en_q;
  logic                  busy_q, done_q;
  logic [dw-1:0]         data_q;

  logic                  idle_c, start_c, fetch_c, last_c;
  logic [rows_w-1:0]     rows_clamp_c;

  function automatic logic [dw-1:0] sat(input logic [ACC_W-1:0] x);
    logic [ACC_W-1:0] s;
    s = x >> out_shift;
    if (s > sat_max) sat = '1;
    else             sat = s[dw-1:0];
  endfunction

  assign idle_c       = (state_q == IDLE);
  assign start_c      = idle_c && i_start;
  assign rows_clamp_c = (i_rows > rows_w'(xbar_size)) ? rows_w'(xbar_size) : i_rows;
  assign last_c       = ({1'b0, row_cnt_q} == (n_rows_q - rows_w'(1)));

  // Next-state and fetch control
  always_comb begin
    state_d = state_q;
    fetch_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = (rows_clamp_c == '0) ? DRAIN : COMPUTE;
      end
      COMPUTE: begin
        fetch_c = 1'b1;
        if (last_c) state_d = DRAIN;
      end
      DRAIN:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Weight RAM: single port, column-slice writes in IDLE, row reads in COMPUTE; not reset
  always_ff @(posedge clk) begin
    if (idle_c && i_w_we) begin
      for (int c = 0; c < int'(xbar_size); c++) begin
        if (i_w_col == addr_w'(c)) w_mem[i_w_row][c*dw +: dw] <= i_w_data;
      end
    end else if (fetch_c) begin
      w_rd_q <= w_mem[row_cnt_q];
    end
  end

  // Input latch, row sequencing, MAC one cycle behind fetch, result commit and read port
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < int'(xbar_size); c++) begin
        in_q[c]  <= '0;
        out_q[c] <= '0;
        acc_q[c] <= '0;
      end
      in_fetch_q <= '0;
      row_cnt_q  <= '0;
      n_rows_q   <= '0;
      mac_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == FINISH);
      data_q   <= out_q[i_rd_addr];
      mac_en_q <= fetch_c;
      if (idle_c && i_we) in_q[i_wr_addr] <= i_wr_data;
      if (start_c) begin
        n_rows_q  <= rows_clamp_c;
        row_cnt_q <= '0;
        for (int c = 0; c < int'(xbar_size); c++) acc_q[c] <= '0;
      end else if (mac_en_q) begin
        for (int c = 0; c < int'(xbar_size); c++) begin
          acc_q[c] <= acc_q[c] + ACC_W'(in_fetch_q) * ACC_W'(w_rd_q[c*dw +: dw]);
        end
      end
      if (fetch_c) begin
        in_fetch_q <= in_q[row_cnt_q];
        row_cnt_q  <= row_cnt_q + addr_w'(1);
      end
      if (state_q == FINISH) begin
        for (int c = 0; c < int'(xbar_size); c++) out_q[c] <= sat(acc_q[c]);
      end
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_data = data_q;

endmodule
